mult4_circuit: RTL and testbench
================================

Name: mult4_circuit

Overview:
- Sequential 4x4 unsigned shift-add multiplier with a start handshake.
- It captures bit-level operands A3..A0 and B3..B0 and iterates one partial product per clock.
- It drives the 8-bit product on out7..out0 and holds it until the next operation completes.
- Standalone arithmetic block: a controller FSM plus a datapath (accumulator/shift register, step counter, output register).

Parameters:
- None. Operand width is fixed at 4 bits and product width at 8 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- start  input  1  start request; one operation is a high pulse followed by a return to low.
- A3, A2, A1, A0  input  1 each  multiplicand, A3 = MSB.
- B3, B2, B1, B0  input  1 each  multiplier, B3 = MSB.
- out7 .. out0  output  1 each  registered product, out7 = MSB.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE; accumulator, multiplier shift register, counter and output register all clear to 0; out7..out0 = 0.
- FSM states: IDLE, WAIT_LOW, CALC, DONE.
  - IDLE: if start=1, go to WAIT_LOW; otherwise stay.
  - WAIT_LOW: stay while start=1. On the first edge with start=0, load operands and go to CALC.
  - CALC: one add/shift step per cycle. After the 4th step, go to DONE.
  - DONE: copy the product to the output register, then go to IDLE.
- Operand load (WAIT_LOW exit edge):
  - Multiplicand register <= {A3..A0}.
  - 9-bit working register P <= {carry=0, acc=0000, B3..B0}.
  - Step counter <= 0.
- Operands are sampled only at the load edge. Changes to A/B at any other time have no effect.
- CALC step:
  - If P[0]=1: {carry, acc} = acc + A (5-bit sum). Otherwise {carry, acc} = {0, acc}.
  - Then P <= {carry, acc, P[3:1]} shifted right by one (logical, carry shifts into the acc MSB).
  - Counter increments.
  - After 4 steps, P[7:0] is the exact product; no overflow is possible (max 15*15 = 225).
- Latency:
  - Edge L samples start=0 in WAIT_LOW and loads.
  - Edges L+1..L+4 perform the steps.
  - Edge L+5 (DONE) updates out7..out0. The product is visible after edge L+5; the FSM is back in IDLE.
- Output register holds its value from DONE until the next DONE or until reset; it does not change during CALC.
- start asserted during CALC/DONE is ignored. A new operation requires start to be seen high in IDLE.
- start held high indefinitely: the block waits in WAIT_LOW; no computation starts.
- Reset asserted mid-operation aborts immediately; outputs return to 0; no partial product appears.
- Zero operand (A=0 or B=0) yields product 0 with the same latency.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> out7..out0 = 00000000; FSM in IDLE.
- Basic: A=0111, B=0010; pulse start high 1 cycle then low -> out = 00001110 (14) 5 cycles after the start-low sampling edge; value holds ~25 cycles afterwards.
- Extremes: A=1111, B=1111 -> out = 11100001 (225). A=0000, B=1011 -> out = 0. A=1000, B=0001 -> 00001000.
- Operand change after load: load A=0011, B=0101, then change A/B to 1111 during CALC -> out = 00001111 (15).
- Mid-operation reset: start A=1111, B=1111, assert rst=0 two cycles into CALC -> out immediately 0. After release, a new A=0010, B=0011 operation -> 00000110.
- Back-to-back and start held high: after the first result, a second pulse with A=0101, B=0101 -> out changes from the old value to 00011001 (25) only at its DONE edge. Holding start high 10 cycles delays the computation until start falls.

Source files
------------

// File: rtl/mult4_circuit.sv
// Sequential 4x4 unsigned shift-add multiplier with a start handshake.
// One partial product per clock; the registered product is held until the next operation completes.
module mult4_circuit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       A3,
  input  logic       A2,
  input  logic       A1,
  input  logic       A0,
  input  logic       B3,
  input  logic       B2,
  input  logic       B1,
  input  logic       B0,
  output logic       out7,
  output logic       out6,
  output logic       out5,
  output logic       out4,
  output logic       out3,
  output logic       out2,
  output logic       out1,
  output logic       out0,
  output logic [1:0] state_dbg
);

  // Handshake: an operation is start high seen in IDLE, followed by start low.
  // The low-sampling edge loads the operands; start is ignored in CALC and DONE.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LOW = 2'd1,
    CALC     = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        load, step, capture;
  logic [3:0]  mcand;
  logic [8:0]  p;
  logic [2:0]  cnt;
  logic [7:0]  prod;
  logic [4:0]  sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE:     if (start) state_next = WAIT_LOW;
      WAIT_LOW: if (!start) begin
                  load       = 1'b1;
                  state_next = CALC;
                end
      CALC:     begin
                  step = 1'b1;
                  if (cnt == 3'd3) state_next = DONE;
                end
      DONE:     begin
                  capture    = 1'b1;
                  state_next = IDLE;
                end
      default:  state_next = IDLE;
    endcase
  end

  // Conditional add of the multiplicand into the accumulator; the carry lands in sum[4].
  assign sum = p[0] ? ({1'b0, p[7:4]} + {1'b0, mcand}) : {1'b0, p[7:4]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand <= 4'd0;
      p     <= 9'd0;
      cnt   <= 3'd0;
      prod  <= 8'd0;
    end else begin
      if (load) begin
        mcand <= {A3, A2, A1, A0};
        p     <= {5'd0, B3, B2, B1, B0};
        cnt   <= 3'd0;
      end else if (step) begin
        p   <= {1'b0, sum, p[3:1]};
        cnt <= cnt + 3'd1;
      end
      if (capture) prod <= p[7:0];
    end
  end

  assign {out7, out6, out5, out4, out3, out2, out1, out0} = prod;
  assign state_dbg = state;

endmodule

// File: tb/tb_mult4_circuit.sv
// Directed bench for mult4_circuit: hand-computed products, latency, hold, abort and handshake cases.
module tb_mult4_circuit;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_LOW = 2'd1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a, b;
  logic [7:0] out;
  logic [1:0] state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  mult4_circuit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A3        (a[3]),
    .A2        (a[2]),
    .A1        (a[1]),
    .A0        (a[0]),
    .B3        (b[3]),
    .B2        (b[2]),
    .B1        (b[1]),
    .B0        (b[0]),
    .out7      (out[7]),
    .out6      (out[6]),
    .out5      (out[5]),
    .out4      (out[4]),
    .out3      (out[3]),
    .out2      (out[2]),
    .out1      (out[1]),
    .out0      (out[0]),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%02h), expected %0d (0x%02h)", tag, observed, observed, expected, expected);
    end
  endtask

  // Runs one operation from the negedge. hold = cycles start stays high.
  // disturb = change operands and pulse start while CALC is running.
  task automatic run_op(input string tag, input logic [3:0] op_a, input logic [3:0] op_b,
                        input int hold, input bit disturb,
                        input logic [7:0] old_val, input logic [7:0] exp_val);
    @(negedge clk);
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_wait_state"}, {6'd0, state_dbg}, {6'd0, S_WAIT_LOW});
    end
    start = 1'b0;
    @(negedge clk);  // load edge L has passed
    if (disturb) begin
      a     = 4'hF;
      b     = 4'hF;
      start = 1'b1;
    end
    @(negedge clk);  // L+1
    start = 1'b0;
    repeat (3) @(negedge clk);  // L+4
    check({tag, "_before_done"}, out, old_val);
    @(negedge clk);  // L+5
    check({tag, "_product"}, out, exp_val);
    check({tag, "_idle"}, {6'd0, state_dbg}, {6'd0, S_IDLE});
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    a     = 4'd0;
    b     = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_out", out, 8'd0);
    check("reset_state", {6'd0, state_dbg}, {6'd0, S_IDLE});
    rst = 1'b1;

    run_op("basic_7x2", 4'b0111, 4'b0010, 1, 1'b0, 8'd0, 8'd14);
    repeat (25) @(negedge clk);
    check("basic_hold", out, 8'd14);

    run_op("max_15x15", 4'b1111, 4'b1111, 1, 1'b0, 8'd14, 8'd225);
    run_op("zero_a", 4'b0000, 4'b1011, 1, 1'b0, 8'd225, 8'd0);
    run_op("8x1", 4'b1000, 4'b0001, 1, 1'b0, 8'd0, 8'd8);
    run_op("late_change", 4'b0011, 4'b0101, 1, 1'b1, 8'd8, 8'd15);

    // Abort two steps into CALC: outputs clear at once, no partial product appears.
    @(negedge clk);
    a = 4'hF; b = 4'hF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);  // L, L+1, L+2
    rst = 1'b0;
    #1;
    check("abort_out", out, 8'd0);
    check("abort_state", {6'd0, state_dbg}, {6'd0, S_IDLE});
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_no_partial", out, 8'd0);

    run_op("after_abort_2x3", 4'b0010, 4'b0011, 1, 1'b0, 8'd0, 8'd6);
    run_op("b2b_5x5", 4'b0101, 4'b0101, 1, 1'b0, 8'd6, 8'd25);
    run_op("held_3x5", 4'b0011, 4'b0101, 10, 1'b0, 8'd25, 8'd15);
    run_op("zero_b", 4'b1101, 4'b0000, 2, 1'b0, 8'd15, 8'd0);
    run_op("13x11", 4'b1101, 4'b1011, 1, 1'b0, 8'd0, 8'd143);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
